// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit.
//   - funct3 encodings of the eight M-extension operations
//   - FSM state encoding (IDLE -> CALC -> FIX -> DONE)
//   - small decode helpers on the funct3 field
package alu_muldiv_seq_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdStateT;

    function automatic logic opIsMul(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic opIsRem(input logic [2:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Ops whose result is the upper half of the double-width product.
    function automatic logic opIsMulHigh(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic opSignedA(input logic [2:0] op);
        case (op)
            OP_MULHU, OP_DIVU, OP_REMU: return 1'b0;
            default:                    return 1'b1;
        endcase
    endfunction

    function automatic logic opSignedB(input logic [2:0] op);
        case (op)
            OP_MULHSU, OP_MULHU, OP_DIVU, OP_REMU: return 1'b0;
            default:                               return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// Datapath building blocks for alu_muldiv_seq.
//
// muldiv_cla : W-bit parallel-prefix (lookahead-carry) adder.
//   a, b [W-1:0] in, cin in, sum [W-1:0] out (carry-out is recovered by
//   widening the operands when a caller needs it).
//
// muldiv_step : one radix-2 iteration, purely combinational.
//   isDiv in          1 = restoring-divide step, 0 = shift-add multiply step
//   hi    in  [W-1:0] accumulator high half / partial remainder
//   lo    in  [W-1:0] multiplier bits / dividend-then-quotient bits
//   m     in  [W-1:0] multiplicand / divisor magnitude
//   hiNext, loNext out: register values after this iteration
module muldiv_cla #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);
    logic [W-1:0] propS;
    logic [W-1:0] grpGenS;
    logic [W-1:0] grpPropS;

    // Kogge-Stone prefix: grpGenS[i] ends up as the carry out of bit i.
    always_comb begin
        propS    = a ^ b;
        grpGenS  = a & b;
        grpPropS = propS;
        grpGenS[0] = grpGenS[0] | (grpPropS[0] & cin);
        for (int d = 1; d < W; d = d << 1) begin
            // Descending index so each stage reads the previous stage's values.
            for (int i = W - 1; i >= d; i--) begin
                grpGenS[i]  = grpGenS[i] | (grpPropS[i] & grpGenS[i-d]);
                grpPropS[i] = grpPropS[i] & grpPropS[i-d];
            end
        end
        sum = propS ^ {grpGenS[W-2:0], cin};
    end
endmodule

module muldiv_step #(
    parameter int W = 32
) (
    input  logic         isDiv,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] m,
    output logic [W-1:0] hiNext,
    output logic [W-1:0] loNext
);
    logic [W:0]   shiftS;
    logic [W+1:0] addAS;
    logic [W+1:0] addBS;
    logic         cinS;
    logic [W+1:0] sumS;
    logic         borrowS;

    // Adder operand select: trial subtract (divide) or conditional add (multiply).
    // Two guard bits: the divide borrow lands in bit W+1, the multiply carry in bit W.
    always_comb begin
        shiftS = {hi, lo[W-1]};
        if (isDiv) begin
            addAS = {1'b0, shiftS};
            addBS = ~{2'b00, m};
            cinS  = 1'b1;
        end else begin
            addAS = {2'b00, hi};
            if (lo[0]) begin
                addBS = {2'b00, m};
            end else begin
                addBS = {(W+2){1'b0}};
            end
            cinS  = 1'b0;
        end
    end

    muldiv_cla #(.W(W + 2)) uAdd (
        .a   (addAS),
        .b   (addBS),
        .cin (cinS),
        .sum (sumS)
    );

    // Next-state of the shared hi/lo registers.
    always_comb begin
        borrowS = sumS[W+1];
        if (isDiv) begin
            // Remainder stays below the divisor, so W bits always hold it after restore.
            if (borrowS) begin
                hiNext = shiftS[W-1:0];
            end else begin
                hiNext = sumS[W-1:0];
            end
            loNext = {lo[W-2:0], ~borrowS};
        end else begin
            hiNext = sumS[W:1];
            loNext = {sumS[0], lo[W-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit (radix-2: shift-add multiply,
// restoring divide, one result bit per cycle) beside the EX-stage ALU.
// Ports:
//   iClk, iRst        clock (rising) / asynchronous active-high reset
//   iValid, oReady    request handshake (oReady high only in IDLE)
//   iOp               funct3 of the M-ext op
//   iDataA, iDataB    rs1 / rs2 operands
//   iFlush            synchronous abort of any in-flight op
//   oValid, iReady    result handshake (oValid held until accepted)
//   oData             result
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iDataA,
    input  logic [WIDTH-1:0] iDataB,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData
);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    mdStateT          stateR, nextStateS;
    logic [CNT_W-1:0] countR;
    logic [WIDTH-1:0] hiR, loR, mR;
    logic [2:0]       opR;
    logic             negResR;

    logic             loadS, signAS, signBS, negResS;
    logic             specialS;
    logic [WIDTH-1:0] specResS;
    logic [WIDTH-1:0] absAS, absBS;
    logic [WIDTH-1:0] negAInS, negAOutS, negBOutS;
    logic             negACinS;
    logic [WIDTH-1:0] fixSelS, fixResS;
    logic             fixCinS;
    logic [WIDTH-1:0] stepHiS, stepLoS;

    // Next-state logic; flush overrides everything, including a same-cycle request.
    always_comb begin
        nextStateS = stateR;
        if (iFlush) begin
            nextStateS = IDLE;
        end else begin
            case (stateR)
                IDLE: begin
                    if (iValid && oReady) begin
                        nextStateS = specialS ? DONE : CALC;
                    end else begin
                        nextStateS = IDLE;
                    end
                end
                CALC: begin
                    if (countR == CNT_ONE) begin
                        nextStateS = FIX;
                    end else begin
                        nextStateS = CALC;
                    end
                end
                FIX:     nextStateS = DONE;
                DONE: begin
                    if (iReady) begin
                        nextStateS = IDLE;
                    end else begin
                        nextStateS = DONE;
                    end
                end
                default: nextStateS = IDLE;
            endcase
        end
    end

    // Accept-time decode: operand signs, result sign, and the divide special cases.
    always_comb begin
        loadS    = iValid && oReady && !iFlush;
        signAS   = opSignedA(iOp) && iDataA[WIDTH-1];
        signBS   = opSignedB(iOp) && iDataB[WIDTH-1];
        negResS  = opIsRem(iOp) ? signAS : (signAS ^ signBS);
        specialS = 1'b0;
        specResS = {WIDTH{1'b0}};
        if (!opIsMul(iOp)) begin
            if (iDataB == {WIDTH{1'b0}}) begin
                specialS = 1'b1;
                specResS = opIsRem(iOp) ? iDataA : {WIDTH{1'b1}};
            end else if ((iOp == OP_DIV || iOp == OP_REM) && iDataA == MIN_INT
                         && iDataB == {WIDTH{1'b1}}) begin
                specialS = 1'b1;
                specResS = opIsRem(iOp) ? {WIDTH{1'b0}} : MIN_INT;
            end else begin
                specialS = 1'b0;
            end
        end else begin
            specialS = 1'b0;
        end
    end

    // Result select and sign fix-up. A negated high product half only takes
    // the +1 when the whole low half is zero (two's complement of 2*WIDTH bits).
    always_comb begin
        if (opIsMulHigh(opR) || opIsRem(opR)) begin
            fixSelS = hiR;
        end else begin
            fixSelS = loR;
        end
        if (opIsMulHigh(opR)) begin
            fixCinS = (loR == {WIDTH{1'b0}});
        end else begin
            fixCinS = 1'b1;
        end
        fixResS = negResR ? negAOutS : fixSelS;
    end

    // Negator A is shared: operand A magnitude in IDLE, result negation in FIX.
    always_comb begin
        if (stateR == FIX) begin
            negAInS  = ~fixSelS;
            negACinS = fixCinS;
        end else begin
            negAInS  = ~iDataA;
            negACinS = 1'b1;
        end
        absAS = signAS ? negAOutS : iDataA;
        absBS = signBS ? negBOutS : iDataB;
    end

    muldiv_cla #(.W(WIDTH)) uNegA (
        .a   (negAInS),
        .b   ({WIDTH{1'b0}}),
        .cin (negACinS),
        .sum (negAOutS)
    );

    muldiv_cla #(.W(WIDTH)) uNegB (
        .a   (~iDataB),
        .b   ({WIDTH{1'b0}}),
        .cin (1'b1),
        .sum (negBOutS)
    );

    muldiv_step #(.W(WIDTH)) uStep (
        .isDiv  (!opIsMul(opR)),
        .hi     (hiR),
        .lo     (loR),
        .m      (mR),
        .hiNext (stepHiS),
        .loNext (stepLoS)
    );

    // State, datapath and registered handshake outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateR  <= IDLE;
            countR  <= {CNT_W{1'b0}};
            hiR     <= {WIDTH{1'b0}};
            loR     <= {WIDTH{1'b0}};
            mR      <= {WIDTH{1'b0}};
            opR     <= 3'b000;
            negResR <= 1'b0;
            oReady  <= 1'b1;
            oValid  <= 1'b0;
            oData   <= {WIDTH{1'b0}};
        end else begin
            stateR <= nextStateS;
            oReady <= (nextStateS == IDLE);
            oValid <= (nextStateS == DONE);
            case (stateR)
                IDLE: begin
                    if (loadS) begin
                        opR     <= iOp;
                        negResR <= negResS;
                        countR  <= CNT_INIT;
                        hiR     <= {WIDTH{1'b0}};
                        loR     <= absAS;
                        mR      <= absBS;
                        if (specialS) begin
                            oData <= specResS;
                        end
                    end
                end
                CALC: begin
                    hiR    <= stepHiS;
                    loR    <= stepLoS;
                    countR <= countR - CNT_ONE;
                end
                FIX:     oData <= fixResS;
                DONE:    begin end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
    import alu_muldiv_seq_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iValid = 1'b0;
    logic        oReady;
    logic [2:0]  iOp = 3'b000;
    logic [31:0] iDataA = 32'h0;
    logic [31:0] iDataB = 32'h0;
    logic        iFlush = 1'b0;
    logic        oValid;
    logic        iReady = 1'b1;
    logic [31:0] oData;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
        string       name;
    } expT;

    expT sbQ[$];
    bit  firstSeen = 1'b0;

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iOp    (iOp),
        .iDataA (iDataA),
        .iDataB (iDataB),
        .iFlush (iFlush),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Monitor: latency on first oValid, data on handshake.
    always @(negedge iClk) begin
        if (iRst) begin
            firstSeen = 1'b0;
        end else if (oValid) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: oValid=1 oData=%h, no result expected", oData);
            end else begin
                if (!firstSeen) begin
                    firstSeen = 1'b1;
                    checks++;
                    if (cyc - sbQ[0].acc != sbQ[0].lat) begin
                        errors++;
                        $display("FAIL %s_latency: got %0d cycles, expected %0d",
                                 sbQ[0].name, cyc - sbQ[0].acc, sbQ[0].lat);
                    end
                end
                if (iReady) begin
                    checks++;
                    if (oData !== sbQ[0].data) begin
                        errors++;
                        $display("FAIL %s: got %h, expected %h", sbQ[0].name, oData, sbQ[0].data);
                    end
                    void'(sbQ.pop_front());
                    firstSeen = 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push, input string nm);
        expT e;
        int  n = 0;
        while (!oReady && n < 200) begin
            @(posedge iClk); #1;
            n++;
        end
        if (!oReady) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: oReady=%b, expected 1", nm, oReady);
        end
        iValid = 1'b1;
        iOp    = op;
        iDataA = a;
        iDataB = b;
        if (push) begin
            e.data = exp;
            e.lat  = lat;
            e.acc  = cyc;
            e.name = nm;
            sbQ.push_back(e);
        end
        @(posedge iClk); #1;
        iValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(posedge iClk); #1;
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbQ.size());
            sbQ.delete();
        end
        @(posedge iClk); #1;
    endtask

    initial begin
        repeat (3) @(posedge iClk);
        #1;
        check("reset_oReady", {31'h0, oReady}, 32'h1);
        check("reset_oValid", {31'h0, oValid}, 32'h0);
        check("reset_oData", oData, 32'h0);
        iRst = 1'b0;
        @(posedge iClk); #1;

        issue(OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1, "mul_7_m3");
        issue(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b1, "mulh_min_min");
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b1, "mulhu_max");
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b1, "mulhsu_m1");
        issue(OP_MUL,    32'h12345678, 32'h00000009, 32'hA3D70A38, 34, 1'b1, "mul_x9");
        issue(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 34, 1'b1, "div_m7_2");
        issue(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 34, 1'b1, "rem_m7_2");
        issue(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b1, "div_7_m2");
        issue(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34, 1'b1, "rem_7_m2");
        issue(OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 34, 1'b1, "divu_100_7");
        issue(OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 34, 1'b1, "remu_100_7");
        issue(OP_DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 34, 1'b1, "divu_max_1");
        issue(OP_DIV,    32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1,  1'b1, "div_by0");
        issue(OP_REMU,   32'h00000005, 32'h00000000, 32'h00000005, 1,  1'b1, "remu_by0");
        issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b1, "div_ovf");
        issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b1, "rem_ovf");
        drain();

        // Backpressure: hold iReady low in DONE while a new request is offered.
        iReady = 1'b0;
        issue(OP_DIVU, 32'h00000064, 32'h00000007, 32'h0000000E, 34, 1'b1, "bp_divu");
        begin
            int n = 0;
            while (!oValid && n < 100) begin
                @(posedge iClk); #1;
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_oValid", {31'h0, oValid}, 32'h1);
            check("bp_oData", oData, 32'h0000000E);
            check("bp_oReady", {31'h0, oReady}, 32'h0);
            iValid = 1'b1;
            iOp    = OP_DIVU;
            iDataA = 32'h00000009;
            iDataB = 32'h00000003;
            @(posedge iClk); #1;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        @(posedge iClk); #1;
        check("bp_release_oValid", {31'h0, oValid}, 32'h0);
        check("bp_release_oReady", {31'h0, oReady}, 32'h1);
        drain();

        // Flush in the 10th CALC cycle: no result, ready again next cycle.
        issue(OP_MUL, 32'h00001234, 32'h00005678, 32'h0, 0, 1'b0, "flush_mul");
        repeat (9) begin
            @(posedge iClk); #1;
        end
        iFlush = 1'b1;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        check("flush_oValid", {31'h0, oValid}, 32'h0);
        check("flush_oReady", {31'h0, oReady}, 32'h1);

        // Flush beats a same-cycle request (a special case would otherwise finish next cycle).
        iValid = 1'b1;
        iFlush = 1'b1;
        iOp    = OP_DIV;
        iDataA = 32'h00000005;
        iDataB = 32'h00000000;
        @(posedge iClk); #1;
        iValid = 1'b0;
        iFlush = 1'b0;
        check("flush_wins_oValid", {31'h0, oValid}, 32'h0);
        check("flush_wins_oReady", {31'h0, oReady}, 32'h1);

        // Asynchronous reset in the middle of CALC.
        issue(OP_DIV, 32'h000003E8, 32'h00000003, 32'h0, 0, 1'b0, "rst_div");
        repeat (5) begin
            @(posedge iClk); #1;
        end
        #2;
        iRst = 1'b1;
        #1;
        check("rst_mid_oReady", {31'h0, oReady}, 32'h1);
        check("rst_mid_oValid", {31'h0, oValid}, 32'h0);
        check("rst_mid_oData", oData, 32'h0);
        @(posedge iClk); #1;
        iRst = 1'b0;
        repeat (40) begin
            @(posedge iClk); #1;
        end

        issue(OP_MUL, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b1, "fresh_mul");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
